// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use bubbles, E-stage redirects,
// and holding Execute while the multi-cycle mul/div unit works.
module pipe_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LoadE,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             PCsrcE,
    input  logic             MdE,
    input  logic             md_done,
    output logic             md_start,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TO_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [TO_W-1:0]   to_reg, to_next;
    logic              md_err_reg, md_err_next;
    logic [CNT_W-1:0]  cnt_reg;

    logic lu;
    logic hz_stall, hz_fd, hz_fe;
    logic md_start_c, sf_c, sd_c, se_c, fd_c, fe_c, fm_c;

    // A taken redirect always wins over a load-use hold so the fetch is never blocked.
    always_comb begin
        lu       = LoadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
        hz_stall = lu && !PCsrcE;
        hz_fd    = PCsrcE;
        hz_fe    = PCsrcE || lu;
    end

    always_comb begin
        state_next  = state_reg;
        to_next     = to_reg;
        md_err_next = md_err_reg;
        md_start_c  = 1'b0;
        sf_c        = 1'b0;
        sd_c        = 1'b0;
        se_c        = 1'b0;
        fd_c        = 1'b0;
        fe_c        = 1'b0;
        fm_c        = 1'b0;
        case (state_reg)
            IDLE: begin
                to_next = '0;
                if (MdE) begin
                    md_start_c = 1'b1;
                    sf_c       = 1'b1;
                    sd_c       = 1'b1;
                    se_c       = 1'b1;
                    state_next = BUSY;
                end else begin
                    sf_c = hz_stall;
                    sd_c = hz_stall;
                    fd_c = hz_fd;
                    fe_c = hz_fe;
                end
            end
            BUSY: begin
                to_next = to_reg + 1'b1;
                if (md_done) begin
                    state_next = DONE;
                end else begin
                    sf_c = 1'b1;
                    sd_c = 1'b1;
                    se_c = 1'b1;
                    fm_c = 1'b1;
                    if (to_reg == TO_LAST) begin
                        md_err_next = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                // MdE is still the same instruction here; it must not restart the unit.
                to_next    = '0;
                state_next = IDLE;
                sf_c       = hz_stall;
                sd_c       = hz_stall;
                fd_c       = hz_fd;
                fe_c       = hz_fe;
            end
            default: begin
                to_next    = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            to_reg     <= '0;
            md_err_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            to_reg     <= to_next;
            md_err_reg <= md_err_next;
            if (StallF && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign md_start  = rst & md_start_c;
    assign StallF    = rst & sf_c;
    assign StallD    = rst & sd_c;
    assign StallE    = rst & se_c;
    assign FlushD    = rst & fd_c;
    assign FlushE    = rst & fe_c;
    assign FlushM    = rst & fm_c;
    assign md_err    = md_err_reg;
    assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: a rule-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_pipe_stall_ctrl;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             LoadE = 1'b0;
    logic [4:0]       rdE = '0;
    logic [4:0]       rs1D = '0;
    logic [4:0]       rs2D = '0;
    logic             PCsrcE = 1'b0;
    logic             MdE = 1'b0;
    logic             md_done = 1'b0;
    logic             md_start, StallF, StallD, StallE, FlushD, FlushE, FlushM, md_err;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .LoadE(LoadE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D),
        .PCsrcE(PCsrcE), .MdE(MdE), .md_done(md_done), .md_start(md_start),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
        .FlushE(FlushE), .FlushM(FlushM), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: md_age < 0 means no mul/div op is being waited on; otherwise it counts
    // cycles spent waiting. after_md marks the single cycle following a finished op.
    typedef struct packed {
        logic ms, sf, sd, se, fd, fe, fm;
    } ctl_t;

    int m_age     = -1;
    bit after_md  = 1'b0;
    bit m_err     = 1'b0;
    int m_cnt     = 0;

    function automatic ctl_t exp_ctl();
        ctl_t c;
        bit   hazard;
        c = '0;
        if (!rst) return c;
        hazard = LoadE && (rdE != 0) && ((rdE == rs1D) || (rdE == rs2D));
        if (m_age >= 0) begin
            c.sf = !md_done; c.sd = !md_done; c.se = !md_done; c.fm = !md_done;
        end else if (!after_md && MdE) begin
            c.ms = 1'b1; c.sf = 1'b1; c.sd = 1'b1; c.se = 1'b1;
        end else if (PCsrcE) begin
            c.fd = 1'b1; c.fe = 1'b1;
        end else if (hazard) begin
            c.sf = 1'b1; c.sd = 1'b1; c.fe = 1'b1;
        end
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin
        ctl_t e;
        if (!rst) begin
            m_age = -1; after_md = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            e = exp_ctl();
            if (e.sf && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (m_age >= 0) begin
                if (md_done) begin
                    m_age = -1; after_md = 1'b1;
                end else if (m_age == MD_TIMEOUT - 1) begin
                    m_age = -1; after_md = 1'b1; m_err = 1'b1;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (after_md) begin
                after_md = 1'b0;
            end else if (MdE) begin
                m_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        ctl_t e;
        e = exp_ctl();
        chk("md_start", 32'(md_start), 32'(e.ms));
        chk("StallF",   32'(StallF),   32'(e.sf));
        chk("StallD",   32'(StallD),   32'(e.sd));
        chk("StallE",   32'(StallE),   32'(e.se));
        chk("FlushD",   32'(FlushD),   32'(e.fd));
        chk("FlushE",   32'(FlushE),   32'(e.fe));
        chk("FlushM",   32'(FlushM),   32'(e.fm));
        chk("md_err",   32'(md_err),   32'(m_err));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_md_err", 32'(md_err), 32'd0);
        chk("rst_StallF", 32'(StallF), 32'd0);
        $display("txn reset: stall_cnt=%0d md_err=%0d", stall_cnt, md_err);
        step();
        rst = 1'b1;
        step();

        // Load-use on rs2
        LoadE = 1'b1; rdE = 5'd5; rs2D = 5'd5; #1;
        chk("lu_StallF", 32'(StallF), 32'd1);
        chk("lu_StallD", 32'(StallD), 32'd1);
        chk("lu_FlushE", 32'(FlushE), 32'd1);
        chk("lu_StallE", 32'(StallE), 32'd0);
        step();
        LoadE = 1'b0; #1;
        chk("lu_one_bubble", 32'(StallF), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        $display("txn load-use: stall_cnt=%0d", stall_cnt);

        // Load to x0 never stalls
        LoadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0; #1;
        chk("x0_StallF", 32'(StallF), 32'd0);
        chk("x0_FlushE", 32'(FlushE), 32'd0);
        step();
        $display("txn load-x0: StallF=%0d", StallF);

        // Branch together with load-use
        rdE = 5'd5; rs1D = 5'd5; PCsrcE = 1'b1; #1;
        chk("br_FlushD", 32'(FlushD), 32'd1);
        chk("br_FlushE", 32'(FlushE), 32'd1);
        chk("br_StallF", 32'(StallF), 32'd0);
        chk("br_StallD", 32'(StallD), 32'd0);
        step();
        LoadE = 1'b0; PCsrcE = 1'b0;
        $display("txn branch+lu: FlushD=%0d", FlushD);

        // Mul/div with md_done four cycles after start
        MdE = 1'b1; #1;
        chk("md_start_pulse", 32'(md_start), 32'd1);
        chk("md_StallE0", 32'(StallE), 32'd1);
        chk("md_FlushM0", 32'(FlushM), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(); #1;
            chk("md_busy_start", 32'(md_start), 32'd0);
            chk("md_busy_StallE", 32'(StallE), 32'd1);
            chk("md_busy_FlushM", 32'(FlushM), 32'd1);
        end
        step();
        md_done = 1'b1; #1;
        chk("md_done_StallE", 32'(StallE), 32'd0);
        chk("md_done_FlushM", 32'(FlushM), 32'd0);
        step();
        md_done = 1'b0; #1;
        chk("md_done_state_start", 32'(md_start), 32'd0);
        chk("md_done_state_StallE", 32'(StallE), 32'd0);
        step();
        MdE = 1'b0; #1;
        chk("md_cnt", 32'(stall_cnt), 32'd5);
        $display("txn muldiv: stall_cnt=%0d", stall_cnt);

        // Timeout with md_done never asserted
        MdE = 1'b1;
        step();
        repeat (7) step();
        #1;
        chk("to_err_early", 32'(md_err), 32'd0);
        chk("to_StallF_last", 32'(StallF), 32'd1);
        step(); #1;
        chk("to_err_set", 32'(md_err), 32'd1);
        chk("to_done_StallF", 32'(StallF), 32'd0);
        chk("to_done_start", 32'(md_start), 32'd0);
        chk("to_cnt", 32'(stall_cnt), 32'd14);
        MdE = 1'b0;
        repeat (3) step();
        chk("to_err_sticky", 32'(md_err), 32'd1);
        $display("txn timeout: md_err=%0d stall_cnt=%0d", md_err, stall_cnt);

        // Asynchronous reset in the middle of BUSY
        MdE = 1'b1;
        step();
        step();
        #2; rst = 1'b0; #1;
        chk("arst_StallF", 32'(StallF), 32'd0);
        chk("arst_StallE", 32'(StallE), 32'd0);
        chk("arst_FlushM", 32'(FlushM), 32'd0);
        chk("arst_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_err", 32'(md_err), 32'd0);
        step();
        MdE = 1'b0; rst = 1'b1; #1;
        chk("arst_no_start", 32'(md_start), 32'd0);
        step();
        chk("arst_idle_StallF", 32'(StallF), 32'd0);
        $display("txn async-reset: StallF=%0d stall_cnt=%0d", StallF, stall_cnt);

        // Saturating stall counter
        LoadE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
        repeat (20) step();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        LoadE = 1'b0;
        repeat (2) step();
        chk("sat_hold", 32'(stall_cnt), 32'd15);
        $display("txn saturation: stall_cnt=%0d", stall_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It generates the per-stage stall and flush controls from three sources: load-use hazards, taken branches/jumps resolved in Execute, and a multi-cycle mul/div unit that holds Execute. It sits alongside the forwarding unit. Forwarding covers ALU-to-ALU dependencies; this block covers every hazard that forwarding cannot resolve.

Parameters:
MD_TIMEOUT, 64, maximum BUSY cycles before md_err is raised
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
LoadE  in  1  instruction in E is a load (result from memory)
rdE  in  5  destination register of instruction in E
rs1D  in  5  source register 1 of instruction in D
rs2D  in  5  source register 2 of instruction in D
PCsrcE  in  1  branch/jump taken, resolved in E
MdE  in  1  instruction in E is mul/div
md_done  in  1  mul/div unit result ready, 1-cycle pulse
md_start  out  1  start pulse to mul/div unit
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register (bubble)
FlushM  out  1  clear EX/MEM register (bubble)
md_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles in which StallF was asserted, saturating

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE, timeout counter 0, md_err 0, stall_cnt 0. All other outputs are combinational and evaluate to 0 while rst=0.
- FSM states:
  - IDLE: when MdE=1, assert md_start combinationally for this cycle and go to BUSY. Assert StallF, StallD and StallE in the same cycle.
  - BUSY: StallF, StallD and StallE are 1. FlushM is 1, inserting a bubble into M each cycle. md_start is 0. The timeout counter increments each cycle.
    - md_done=1: go to DONE; stalls drop in this same cycle.
    - Counter reaches MD_TIMEOUT-1 without md_done: set md_err, go to DONE.
  - DONE: a single cycle with no md stalls, so the E result advances to M. Return to IDLE. MdE is ignored in DONE, so the same instruction cannot restart the unit. The timeout counter clears.
- Load-use (combinational): lu = LoadE & (rdE != 0) & (rdE == rs1D | rdE == rs2D).
  - lu=1 in IDLE or DONE: StallF=1, StallD=1, FlushE=1. Exactly one bubble per occurrence, because the load leaves E on the next edge.
- Branch: PCsrcE=1 gives FlushD=1 and FlushE=1 in the same cycle.
- Priorities:
  - PCsrcE overrides lu. When both are 1: StallF=0, StallD=0, FlushD=1, FlushE=1, so the redirect is never blocked.
  - During BUSY (and during the IDLE cycle with MdE=1): lu and PCsrcE are ignored, and FlushD/FlushE are forced to 0 so the held instruction is not killed. A mul/div instruction never asserts PCsrcE.
- md_err stays set until reset.
- stall_cnt increments on every rising edge where StallF=1. It holds at all-ones instead of wrapping.
- Reset asserted mid-BUSY: FSM returns to IDLE immediately. No md_start is issued until MdE is seen again after reset release.

Test Plan:
- Load-use: LoadE=1, rdE=5, rs2D=5, state IDLE -> StallF=StallD=FlushE=1 for exactly 1 cycle, stall_cnt +1. Repeat with rdE=0 -> no stall.
- Branch vs load-use: PCsrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=StallD=0.
- Mul/div: MdE=1, md_done pulsed 4 cycles after md_start -> md_start is a 1-cycle pulse, StallE=1 for 4 cycles, FlushM=1 for the 3 BUSY cycles before the done cycle, then DONE with no stalls, then IDLE. MdE still high in DONE produces no second md_start.
- Timeout: MD_TIMEOUT=8, md_done never asserted -> md_err=1 after 8 BUSY cycles, FSM exits via DONE, md_err stays 1.
- Async reset mid-BUSY: drive rst=0 between clock edges -> stalls drop immediately, state IDLE, stall_cnt=0, md_err=0.
- Saturation: CNT_W=4, 20 stall cycles -> stall_cnt holds at 15.
